// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, fixed BITS+1 cycle latency.
module muldiv_unit #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [BITS-1:0] rs1,
  input  logic [BITS-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [BITS-1:0]   r_a;
  logic [BITS-1:0]   r_b;
  logic [BITS-1:0]   r_hi;
  logic [BITS-1:0]   r_lo;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [BITS-1:0]   r_result;

  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic              w_s1;
  logic              w_s2;
  logic              w_n1;
  logic              w_n2;
  logic [BITS-1:0]   w_m1;
  logic [BITS-1:0]   w_m2;
  logic [BITS:0]     w_sum;
  logic [2*BITS-1:0] w_prod;
  logic [2*BITS-1:0] w_prod_s;
  logic [BITS:0]     w_rsh;
  logic [BITS:0]     w_diff;
  logic              w_qbit;
  logic [BITS-1:0]   w_rem_n;
  logic [BITS-1:0]   w_quo_n;
  logic [BITS-1:0]   w_quo_s;
  logic [BITS-1:0]   w_rem_s;
  logic [BITS-1:0]   w_final;

  assign busy   = (r_state == CALC);
  assign done   = (r_state == DONE);
  assign result = r_result;

  assign w_accept = start & ~flush & (r_state != CALC);
  assign w_step   = (r_state == CALC) & ~flush;
  assign w_last   = (r_cnt == LAST);

  // Operand signedness from funct3; magnitudes feed the datapath
  assign w_s1 = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign w_s2 = op[2] ? ~op[0] : (op[1:0] == 2'b01);
  assign w_n1 = w_s1 & rs1[BITS-1];
  assign w_n2 = w_s2 & rs2[BITS-1];
  assign w_m1 = w_n1 ? -rs1 : rs1;
  assign w_m2 = w_n2 ? -rs2 : rs2;

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_prod   = {w_sum, r_lo[BITS-1:1]};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

  assign w_rsh   = {r_hi, r_lo[BITS-1]};
  assign w_diff  = w_rsh - {1'b0, r_b};
  assign w_qbit  = ~w_diff[BITS];
  assign w_rem_n = w_qbit ? w_diff[BITS-1:0] : w_rsh[BITS-1:0];
  assign w_quo_n = {r_lo[BITS-2:0], w_qbit};

  // Zero divisor forces all-ones quotient regardless of dividend sign
  assign w_quo_s = (r_b == '0) ? '1 :
                   (r_neg_q ? -w_quo_n : w_quo_n);
  assign w_rem_s = r_neg_r ? -w_rem_n : w_rem_n;

  always_comb begin
    w_final = '0;
    unique case (1'b1)
      (r_op == 3'b000):               w_final = w_prod_s[BITS-1:0];
      (~r_op[2] && r_op[1:0] != 2'b00): w_final = w_prod_s[2*BITS-1:BITS];
      (r_op[2] && ~r_op[1]):          w_final = w_quo_s;
      (r_op[2] && r_op[1]):           w_final = w_rem_s;
      default:                        w_final = '0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_n = CALC;
      CALC:    if (w_last) w_state_n = DONE;
      DONE:    w_state_n = start ? CALC : IDLE;
      default: w_state_n = IDLE;
    endcase
    if (flush) w_state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= op;
      r_a     <= w_m1;
      r_b     <= w_m2;
      r_hi    <= '0;
      r_lo    <= op[2] ? w_m1 : w_m2;
      r_neg_q <= w_n1 ^ w_n2;
      r_neg_r <= w_n1;
    end else if (w_step) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_op[2]) begin
        r_hi <= w_rem_n;
        r_lo <= w_quo_n;
      end else begin
        r_hi <= w_sum[BITS:1];
        r_lo <= {w_sum[0], r_lo[BITS-1:1]};
      end
      if (w_last) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, latency,
// flush, reset and back-to-back handling.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  muldiv_unit #(.BITS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next rising edge
  task automatic drive(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in the cycle after the accept edge; leaves in the DONE cycle
  task automatic wait_done(input string tag, input logic [31:0] exp,
                           input bit poke);
    int nb;
    nb = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy === 1'b1 && done === 1'b0) nb++;
      if (poke && i == 4) begin
        start = 1'b1;
        op    = DIV;
        rs1   = 32'd100;
        rs2   = 32'd7;
      end
      if (poke && i == 5) start = 1'b0;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 32'(nb), 32'd32);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, result, exp);
  endtask

  task automatic run(input string tag, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    @(negedge clk);
    drive(o, a, b);
    wait_done(tag, exp, 1'b0);
  endtask

  initial begin
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    rs1   = '0;
    rs2   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);

    rst = 1'b0;
    drive(MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul 7*-3", 32'hFFFF_FFEB, 1'b0);

    run("mulhu -1*-1", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulh -1*-1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run("mulhsu -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF);
    run("mulhu big", MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002);
    run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu", DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    run("remu", REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
    run("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("remu 5/0", REMU, 32'd5, 32'd0, 32'h0000_0005);
    run("rem -5/0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    @(negedge clk);
    drive(MUL, 32'd3, 32'd5);
    wait_done("start ignored", 32'h0000_000F, 1'b1);

    run("b2b first", DIVU, 32'd100, 32'd7, 32'd14);
    drive(REMU, 32'd100, 32'd7);
    wait_done("b2b second", 32'd2, 1'b0);

    flush = 1'b1;
    start = 1'b1;
    op    = MUL;
    rs1   = 32'd6;
    rs2   = 32'd6;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush in done busy", {31'd0, busy}, 32'd0);
    chk("flush in done done", {31'd0, done}, 32'd0);
    chk("flush in done result", result, 32'd2);

    @(negedge clk);
    drive(MUL, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = DIVU;
    rs1   = 32'd50;
    rs2   = 32'd5;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    nd = 0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) nd++;
      @(negedge clk);
    end
    chk("flush no activity", 32'(nd), 32'd0);
    chk("flush result kept", result, 32'd2);

    drive(MUL, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset result", result, 32'd0);
    drive(MUL, 32'd3, 32'd4);
    wait_done("mul 3*4", 32'h0000_000C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
